// File: rtl/ram_inv_r_arbiter.sv
// Single-port owner of the 8x8 inverse-R matrix RAM.
// Arbitrates a scalar writer and a vector reader with round-robin
// fairness, and runs a zero-fill clear of all N*N entries on request.
// Every RAM pin and handshake output comes straight from a flop.
module ram_inv_r_arbiter #(
  parameter int DATA_W = 19,
  parameter int ADDR_W = 6,
  parameter int N      = 8
) (
  input  logic                CK,
  input  logic                RST,
  input  logic                clr_start,
  output logic                clr_busy,
  input  logic                wr_req,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [DATA_W-1:0]   wr_data,
  output logic                wr_gnt,
  input  logic                rd_req,
  input  logic [2:0]          rd_idx,
  input  logic                rd_row,
  output logic                rd_gnt,
  output logic                rd_valid,
  output logic [N*DATA_W-1:0] rd_data,
  output logic [ADDR_W-1:0]   ram_A,
  output logic                ram_WE,
  output logic                ram_OE,
  output logic [DATA_W-1:0]   ram_D,
  output logic                ram_Q_SEL,
  input  logic [N*DATA_W-1:0] ram_Q
);

  localparam int CNT_W = $clog2(N*N);
  localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(N*N-1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLR     = 3'd1,
    WR      = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_t;

  state_t              state_reg, state_next;
  logic [CNT_W-1:0]    clr_cnt_reg, clr_cnt_next;
  logic [CNT_W-1:0]    clr_cnt_inc;
  // 1 = write side wins the next conflict (last grant went to the reader)
  logic                pref_wr_reg, pref_wr_next;

  logic [ADDR_W-1:0]   a_reg, a_next;
  logic                we_reg, we_next;
  logic                oe_reg, oe_next;
  logic [DATA_W-1:0]   d_reg, d_next;
  logic                qsel_reg, qsel_next;
  logic                wr_gnt_reg, wr_gnt_next;
  logic                rd_gnt_reg, rd_gnt_next;
  logic                rd_valid_reg, rd_valid_next;
  logic                clr_busy_reg, clr_busy_next;
  logic                capture;

  logic [DATA_W-1:0]   rd_elem_reg [N];

  assign clr_cnt_inc = clr_cnt_reg + CNT_W'(1);

  // Next-state and next-output decode; outputs are precomputed so they
  // appear registered in the cycle the FSM occupies the matching state.
  always_comb begin
    state_next    = state_reg;
    clr_cnt_next  = clr_cnt_reg;
    pref_wr_next  = pref_wr_reg;
    a_next        = '0;
    we_next       = 1'b0;
    oe_next       = 1'b0;
    d_next        = '0;
    qsel_next     = 1'b0;
    wr_gnt_next   = 1'b0;
    rd_gnt_next   = 1'b0;
    rd_valid_next = 1'b0;
    clr_busy_next = 1'b0;
    capture       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (clr_start) begin
          state_next    = CLR;
          clr_cnt_next  = '0;
          we_next       = 1'b1;
          clr_busy_next = 1'b1;
        end else if (wr_req && (!rd_req || pref_wr_reg)) begin
          state_next   = WR;
          a_next       = wr_addr;
          d_next       = wr_data;
          we_next      = 1'b1;
          wr_gnt_next  = 1'b1;
          pref_wr_next = 1'b0;
        end else if (rd_req) begin
          state_next   = RD_ADDR;
          a_next       = ADDR_W'(rd_idx);
          qsel_next    = rd_row;
          rd_gnt_next  = 1'b1;
          pref_wr_next = 1'b1;
        end
      end
      CLR: begin
        if (clr_cnt_reg == CLR_LAST) begin
          state_next = IDLE;
        end else begin
          clr_cnt_next  = clr_cnt_inc;
          a_next        = ADDR_W'(clr_cnt_inc);
          we_next       = 1'b1;
          clr_busy_next = 1'b1;
        end
      end
      WR: begin
        state_next = IDLE;
      end
      RD_ADDR: begin
        // RAM latched the vector address; keep address/select stable and enable output
        state_next = RD_DATA;
        a_next     = a_reg;
        qsel_next  = qsel_reg;
        oe_next    = 1'b1;
      end
      RD_DATA: begin
        state_next    = IDLE;
        capture       = 1'b1;
        rd_valid_next = 1'b1;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State, counters and all registered outputs; reset aborts any operation.
  always_ff @(posedge CK) begin
    if (RST) begin
      state_reg    <= IDLE;
      clr_cnt_reg  <= '0;
      pref_wr_reg  <= 1'b1;
      a_reg        <= '0;
      we_reg       <= 1'b0;
      oe_reg       <= 1'b0;
      d_reg        <= '0;
      qsel_reg     <= 1'b0;
      wr_gnt_reg   <= 1'b0;
      rd_gnt_reg   <= 1'b0;
      rd_valid_reg <= 1'b0;
      clr_busy_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      clr_cnt_reg  <= clr_cnt_next;
      pref_wr_reg  <= pref_wr_next;
      a_reg        <= a_next;
      we_reg       <= we_next;
      oe_reg       <= oe_next;
      d_reg        <= d_next;
      qsel_reg     <= qsel_next;
      wr_gnt_reg   <= wr_gnt_next;
      rd_gnt_reg   <= rd_gnt_next;
      rd_valid_reg <= rd_valid_next;
      clr_busy_reg <= clr_busy_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_cap
      // Capture element gi of the RAM vector at the end of RD_DATA
      always_ff @(posedge CK) begin
        if (RST) begin
          rd_elem_reg[gi] <= '0;
        end else if (capture) begin
          rd_elem_reg[gi] <= ram_Q[gi*DATA_W +: DATA_W];
        end
      end
      assign rd_data[gi*DATA_W +: DATA_W] = rd_elem_reg[gi];
    end
  endgenerate

  assign clr_busy  = clr_busy_reg;
  assign wr_gnt    = wr_gnt_reg;
  assign rd_gnt    = rd_gnt_reg;
  assign rd_valid  = rd_valid_reg;
  assign ram_A     = a_reg;
  assign ram_WE    = we_reg;
  assign ram_OE    = oe_reg;
  assign ram_D     = d_reg;
  assign ram_Q_SEL = qsel_reg;

endmodule
